// File: rtl/tile_fetch_ctrl.sv
// tile_fetch_ctrl: walks a frame in 8x8 tiles, reads each tile's 64 pixels
// from pixel memory in tile-internal row-major order, and streams them to an
// 8x8 tile buffer through a 4-entry output FIFO. After each tile it waits for
// the buffer's done pulse before moving on to the next tile.
//
// Optional feature: define TILE_FETCH_PERF_EN to build a saturating frame
// cycle counter reported on o_frame_cycles. Without it, o_frame_cycles is 0.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | waiting for i_start
// S_FETCH     | issuing the current tile's 64 reads, FIFO space permitting
// S_DRAIN     | all reads issued; waiting for the tile's 64th beat to leave
// S_WAIT_INTR | tile delivered; waiting for i_buf_intr to advance
// S_DONE      | one-cycle frame-done pulse, tile indices cleared
module tile_fetch_ctrl #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd_en,
    input  logic [31:0]       i_mem_rdata,
    output logic [31:0]       m_axis_data,
    output logic              m_axis_valid,
    input  logic              m_axis_ready,
    input  logic              i_buf_intr,
    output logic              o_busy,
    output logic [7:0]        o_tile_x,
    output logic [7:0]        o_tile_y,
    output logic              o_frame_done,
    output logic [31:0]       o_frame_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WAIT_INTR,
        S_DONE
    } state_t;

    localparam logic [7:0] TX_LAST = 8'(IMG_W / 8 - 1);
    localparam logic [7:0] TY_LAST = 8'(IMG_H / 8 - 1);

    state_t            state_q;
    logic [7:0]        tile_x_q;
    logic [7:0]        tile_y_q;
    logic [5:0]        rd_idx_q;
    logic [5:0]        beat_cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_en_q;
    logic              busy_q;
    logic              frame_done_q;

    logic              rd_vld_q;
    logic [31:0]       fifo_mem_q [4];
    logic [1:0]        wr_ptr_q;
    logic [1:0]        rd_ptr_q;
    logic [2:0]        fifo_cnt_q;

    logic              beat_fire;
    logic              last_beat;
    logic [2:0]        outstanding;
    logic              can_issue;
    logic              tile_last_x;
    logic              last_tile;
    logic [7:0]        next_tile_x;
    logic [7:0]        next_tile_y;
    logic              advance;

    // Pixel address of read idx (r = idx/8, c = idx%8) inside tile (tx, ty).
    // {ty, r} is 8*ty + r and {tx, c} is 8*tx + c.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] tx,
                                                   input logic [7:0] ty,
                                                   input logic [5:0] idx);
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        row = ADDR_W'({ty, idx[5:3]});
        col = ADDR_W'({tx, idx[2:0]});
        return row * ADDR_W'(IMG_W) + col;
    endfunction

    assign m_axis_valid = (fifo_cnt_q != 3'd0);
    assign m_axis_data  = fifo_mem_q[rd_ptr_q];
    assign beat_fire    = m_axis_valid && m_axis_ready;
    assign last_beat    = beat_fire && (beat_cnt_q == 6'd63);

    // Entries already held, plus the read returning this cycle, plus the read
    // issued this cycle: a new read may go out only if all fit in the FIFO.
    assign outstanding  = fifo_cnt_q + {2'b00, mem_rd_en_q} + {2'b00, rd_vld_q};
    assign can_issue    = (outstanding < 3'd4);

    assign tile_last_x  = (tile_x_q == TX_LAST);
    assign last_tile    = tile_last_x && (tile_y_q == TY_LAST);
    assign next_tile_x  = tile_last_x ? 8'd0 : tile_x_q + 8'd1;
    assign next_tile_y  = tile_last_x ? tile_y_q + 8'd1 : tile_y_q;

    // A done pulse landing on the same cycle as the tile's last beat counts.
    assign advance      = i_buf_intr &&
                          ((state_q == S_WAIT_INTR) ||
                           ((state_q == S_DRAIN) && last_beat));

    assign o_mem_addr   = mem_addr_q;
    assign o_mem_rd_en  = mem_rd_en_q;
    assign o_busy       = busy_q;
    assign o_tile_x     = tile_x_q;
    assign o_tile_y     = tile_y_q;
    assign o_frame_done = frame_done_q;

    // Sequencing FSM: read issue, beat counting, tile advance, frame done.
    // The first read of a tile goes out on the edge that enters FETCH, so the
    // first beat is at the FIFO head two cycles later.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q      <= S_IDLE;
            tile_x_q     <= 8'd0;
            tile_y_q     <= 8'd0;
            rd_idx_q     <= 6'd0;
            beat_cnt_q   <= 6'd0;
            mem_addr_q   <= '0;
            mem_rd_en_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            mem_rd_en_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (beat_fire) begin
                beat_cnt_q <= beat_cnt_q + 6'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q     <= S_FETCH;
                        busy_q      <= 1'b1;
                        beat_cnt_q  <= 6'd0;
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= pix_addr(tile_x_q, tile_y_q, 6'd0);
                        rd_idx_q    <= 6'd1;
                    end
                end
                S_FETCH: begin
                    if (can_issue) begin
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= pix_addr(tile_x_q, tile_y_q, rd_idx_q);
                        rd_idx_q    <= rd_idx_q + 6'd1;
                        if (rd_idx_q == 6'd63) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_beat && !i_buf_intr) begin
                        state_q <= S_WAIT_INTR;
                    end
                end
                S_WAIT_INTR: begin
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (advance) begin
                if (last_tile) begin
                    state_q      <= S_DONE;
                    tile_x_q     <= 8'd0;
                    tile_y_q     <= 8'd0;
                    frame_done_q <= 1'b1;
                end else begin
                    state_q     <= S_FETCH;
                    tile_x_q    <= next_tile_x;
                    tile_y_q    <= next_tile_y;
                    mem_rd_en_q <= 1'b1;
                    mem_addr_q  <= pix_addr(next_tile_x, next_tile_y, 6'd0);
                    rd_idx_q    <= 6'd1;
                end
            end
        end
    end

    // Output FIFO: captures read data one cycle after each strobe, pops on
    // handshake. Reset drops both the FIFO and any read still in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rd_vld_q   <= 1'b0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            fifo_cnt_q <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem_q[i] <= 32'd0;
            end
        end else begin
            rd_vld_q <= mem_rd_en_q;
            if (rd_vld_q) begin
                fifo_mem_q[wr_ptr_q] <= i_mem_rdata;
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (beat_fire) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({rd_vld_q, beat_fire})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

`ifdef TILE_FETCH_PERF_EN
    logic [31:0] perf_cnt_q;
    logic [31:0] frame_cycles_q;

    // Frame cycle counter: cleared when a start is accepted, counts every
    // busy cycle (saturating), latched into the report during DONE.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            perf_cnt_q     <= 32'd0;
            frame_cycles_q <= 32'd0;
        end else begin
            if (state_q == S_IDLE) begin
                if (i_start) begin
                    perf_cnt_q <= 32'd0;
                end
            end else if (perf_cnt_q != 32'hFFFF_FFFF) begin
                perf_cnt_q <= perf_cnt_q + 32'd1;
            end
            if (state_q == S_DONE) begin
                frame_cycles_q <= perf_cnt_q;
            end
        end
    end

    assign o_frame_cycles = frame_cycles_q;
`else
    assign o_frame_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_tile_fetch_ctrl.sv
// Bench for tile_fetch_ctrl on a 16x16 frame (four tiles). A random pixel
// memory feeds the DUT; a reference model computes each read address and
// beat value directly from tile/row/column arithmetic.
module tb_tile_fetch_ctrl;

    localparam int W   = 16;
    localparam int H   = 16;
    localparam int AW  = 8;
    localparam int TPR = W / 8;
    localparam int NB  = W * H;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_rd_en;
    logic [31:0]   i_mem_rdata = 32'd0;
    logic [31:0]   m_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready;
    logic          i_buf_intr;
    logic          o_busy;
    logic [7:0]    o_tile_x;
    logic [7:0]    o_tile_y;
    logic          o_frame_done;
    logic [31:0]   o_frame_cycles;

    logic          intr_auto = 1'b0;
    logic          intr_man  = 1'b0;
    assign i_buf_intr = intr_auto | intr_man;

    tile_fetch_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .o_mem_addr     (o_mem_addr),
        .o_mem_rd_en    (o_mem_rd_en),
        .i_mem_rdata    (i_mem_rdata),
        .m_axis_data    (m_axis_data),
        .m_axis_valid   (m_axis_valid),
        .m_axis_ready   (m_axis_ready),
        .i_buf_intr     (i_buf_intr),
        .o_busy         (o_busy),
        .o_tile_x       (o_tile_x),
        .o_tile_y       (o_tile_y),
        .o_frame_done   (o_frame_done),
        .o_frame_cycles (o_frame_cycles)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    logic [31:0]   pix_mem [NB];
    int            issued = 0, accepted = 0, acc_l1 = 0, acc_l2 = 0;
    int            done_cnt = 0, busy_cyc = 0, cyc = 0, intr_cd = 0;
    int            first_beat_cyc = 0, tile0_end_cyc = 0;
    logic          prev_stall = 1'b0;
    logic [31:0]   prev_data = 32'd0;
    logic          prev_rd = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Address of the n-th read of a frame: tile n/64 in raster order,
    // pixel (r, c) = ((n%64)/8, n%8) inside it.
    function automatic int model_addr(input int n);
        int t  = n / 64;
        int k  = n % 64;
        int tx = t % TPR;
        int ty = t / TPR;
        return (8 * ty + k / 8) * W + 8 * tx + k % 8;
    endfunction

    function automatic logic [31:0] model_beat(input int n);
        if (n < NB) return pix_mem[model_addr(n)];
        return 'x;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    // Pixel memory: data for a strobe appears during the following cycle.
    always @(negedge i_clk) begin
        i_mem_rdata = prev_rd ? pix_mem[prev_addr] : $urandom;
        prev_rd     = o_mem_rd_en;
        prev_addr   = o_mem_addr;
    end

    // Monitor: read-address/tile checks, FIFO bound, beat order, stall
    // stability, and the tile buffer's done pulse 3 cycles after each tile.
    always @(negedge i_clk) begin
        cyc++;
        if (!i_rst) begin
            issued     = 0;
            accepted   = 0;
            acc_l1     = 0;
            acc_l2     = 0;
            intr_cd    = 0;
            intr_auto  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            intr_auto = 1'b0;
            if (intr_cd > 0) begin
                intr_cd--;
                if (intr_cd == 0) intr_auto = 1'b1;
            end
            if (o_mem_rd_en) begin
                chk("rd_addr", 32'(o_mem_addr), 32'(model_addr(issued)));
                chk("tile_x", 32'(o_tile_x), 32'((issued / 64) % TPR));
                chk("tile_y", 32'(o_tile_y), 32'((issued / 64) / TPR));
                chk("outstanding_le4", 32'(issued + 1 - acc_l2 <= 4), 32'(1));
                issued++;
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(m_axis_valid), 32'(1));
                chk("stall_data", m_axis_data, prev_data);
            end
            if (m_axis_valid && m_axis_ready) begin
                chk("beat_data", m_axis_data, model_beat(accepted));
                accepted++;
                if (accepted == 1)       first_beat_cyc = cyc;
                if (accepted == 64)      tile0_end_cyc  = cyc;
                if (accepted % 64 == 0)  intr_cd        = 3;
            end
            prev_stall = m_axis_valid && !m_axis_ready;
            prev_data  = m_axis_data;
            acc_l2     = acc_l1;
            acc_l1     = accepted;
            if (o_frame_done) done_cnt++;
            if (o_busy && !o_frame_done) busy_cyc++;
        end
    end

    task automatic start_frame();
        issued   = 0;
        accepted = 0;
        acc_l1   = 0;
        acc_l2   = 0;
        done_cnt = 0;
        busy_cyc = 0;
        i_start  = 1'b1;
        step();
        i_start  = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int n = 0;
        while (done_cnt == 0 && n < 4000) begin
            if (rnd) m_axis_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("done_within_budget", 32'(done_cnt != 0), 32'(1));
        m_axis_ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic frame_checks(input string tag);
        int exp_cycles;
`ifdef TILE_FETCH_PERF_EN
        exp_cycles = busy_cyc;
`else
        exp_cycles = 0;
`endif
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'(1));
        chk({tag, "_beats"}, 32'(accepted), 32'(NB));
        chk({tag, "_reads"}, 32'(issued), 32'(NB));
        chk({tag, "_busy_idle"}, 32'(o_busy), 32'(0));
        chk({tag, "_tile_x_clr"}, 32'(o_tile_x), 32'(0));
        chk({tag, "_tile_y_clr"}, 32'(o_tile_y), 32'(0));
        chk({tag, "_frame_cycles"}, o_frame_cycles, 32'(exp_cycles));
    endtask

    initial begin
        int n;
        i_rst        = 1'b0;
        i_start      = 1'b0;
        m_axis_ready = 1'b0;
        foreach (pix_mem[i]) pix_mem[i] = $urandom;

        // Reset values
        repeat (3) step();
        chk("rst_addr", 32'(o_mem_addr), 32'(0));
        chk("rst_rd_en", 32'(o_mem_rd_en), 32'(0));
        chk("rst_data", m_axis_data, 32'(0));
        chk("rst_valid", 32'(m_axis_valid), 32'(0));
        chk("rst_busy", 32'(o_busy), 32'(0));
        chk("rst_tile_x", 32'(o_tile_x), 32'(0));
        chk("rst_tile_y", 32'(o_tile_y), 32'(0));
        chk("rst_done", 32'(o_frame_done), 32'(0));
        chk("rst_cycles", o_frame_cycles, 32'(0));
        i_rst = 1'b1;
        step();

        // Frame A: ready held high, latency and throughput
        m_axis_ready = 1'b1;
        start_frame();
        chk("busy_after_start", 32'(o_busy), 32'(1));
        step();
        step();
        chk("first_valid_latency", 32'(m_axis_valid), 32'(1));
        wait_done(1'b0);
        frame_checks("A");
        chk("tile0_throughput", 32'(tile0_end_cyc - first_beat_cyc), 32'(63));

        // Frame B: random ready
        start_frame();
        wait_done(1'b1);
        frame_checks("B");

        // Frame C: stall after the third beat
        m_axis_ready = 1'b1;
        start_frame();
        n = 0;
        while (accepted < 3 && n < 50) begin step(); n++; end
        chk("stall_beats_before", 32'(accepted), 32'(3));
        m_axis_ready = 1'b0;
        repeat (10) step();
        chk("stall_no_beats", 32'(accepted), 32'(3));
        chk("stall_buffered_le4", 32'(issued - accepted <= 4), 32'(1));
        chk("stall_rd_en_low", 32'(o_mem_rd_en), 32'(0));
        chk("stall_valid_held", 32'(m_axis_valid), 32'(1));
        m_axis_ready = 1'b1;
        wait_done(1'b0);
        frame_checks("C");

        // Frame D: stray start and stray done pulse while fetching tile 0
        start_frame();
        repeat (4) step();
        i_start  = 1'b1;
        intr_man = 1'b1;
        step();
        i_start  = 1'b0;
        intr_man = 1'b0;
        wait_done(1'b0);
        frame_checks("D");

        // Frame E: reset while tile 2 drains, then a clean restart
        start_frame();
        n = 0;
        while (issued < 192 && n < 2000) begin step(); n++; end
        chk("reach_tile2_drain", 32'(issued), 32'(192));
        i_rst = 1'b0;
        step();
        chk("abort_valid", 32'(m_axis_valid), 32'(0));
        chk("abort_busy", 32'(o_busy), 32'(0));
        chk("abort_rd_en", 32'(o_mem_rd_en), 32'(0));
        chk("abort_tile_x", 32'(o_tile_x), 32'(0));
        chk("abort_tile_y", 32'(o_tile_y), 32'(0));
        i_rst = 1'b1;
        repeat (5) step();
        chk("abort_no_done", 32'(done_cnt), 32'(0));
        chk("abort_idle_valid", 32'(m_axis_valid), 32'(0));
        m_axis_ready = 1'b1;
        start_frame();
        wait_done(1'b0);
        frame_checks("E");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
